// File: rtl/twn_sched_pkg.sv
// Shared types and constants for the TWN frame sequencer: FSM states,
// the prediction FIFO entry layout and the host TDATA packing.
package twn_sched_pkg;

    localparam int CLASSES = 4;
    localparam int FID_W   = 16;
    localparam int TDATA_W = 512;
    localparam int SCORE_W = 16 * CLASSES;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_CREDIT = 2'd1,
        ST_STREAM      = 2'd2,
        ST_DRAIN       = 2'd3
    } state_e;

    typedef struct packed {
        logic [FID_W-1:0]   fid;
        logic               last;
        logic [SCORE_W-1:0] scores;
    } pred_entry_t;

    // Scores in the low bits, frame id in the top bits, everything else zero.
    function automatic logic [TDATA_W-1:0] pack_tdata(input pred_entry_t e);
        logic [TDATA_W-1:0] t;
        t                      = {TDATA_W{1'b0}};
        t[SCORE_W-1:0]         = e.scores;
        t[TDATA_W-1 -: FID_W]  = e.fid;
        return t;
    endfunction

endpackage

// File: rtl/twn_frame_sequencer_pred_fifo.sv
// Synchronous prediction FIFO; the head entry comes straight from storage
// flops, and a push into a full FIFO is accepted when a pop frees the slot.
module pred_fifo
    import twn_sched_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  pred_entry_t      push_data,
    input  logic             pop,
    output pred_entry_t      head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    pred_entry_t      mem_q [DEPTH];
    pred_entry_t      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Next-state: pointer/count update and storage write.
    always_comb begin
        pop_ok_s  = pop && (count_q != {CNT_W{1'b0}});
        push_ok_s = push && ((count_q != CNT_W'(DEPTH)) || pop_ok_s);
        wr_ptr_d  = push_ok_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (push_ok_s && (wr_ptr_q == PTR_W'(i))) ? push_data : mem_q[i];
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/twn_frame_sequencer.sv
// Frame sequencer for the TWN classifier: admits whole I/Q frames only when a
// result slot is guaranteed, tags returned predictions and queues them for the host.
module twn_frame_sequencer
    import twn_sched_pkg::*;
#(
    parameter int  BEATS_PER_FRAME = 256,
    parameter int  MAX_INFLIGHT    = 4,
    localparam int BEAT_W = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1,
    localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_enable,
    input  logic               cfg_start,
    input  logic [15:0]        cfg_num_frames,
    input  logic [31:0]        i_in_TDATA,
    input  logic               i_in_TVALID,
    output logic               i_in_TREADY,
    input  logic [31:0]        q_in_TDATA,
    input  logic               q_in_TVALID,
    output logic               q_in_TREADY,
    output logic               twn_vld_in,
    output logic [63:0]        twn_data_in,
    input  logic               twn_vld_out,
    input  logic [SCORE_W-1:0] twn_data_out,
    output logic [TDATA_W-1:0] predictions_TDATA,
    output logic               predictions_TVALID,
    output logic               predictions_TLAST,
    input  logic               predictions_TREADY,
    output logic               busy,
    output logic               err_spurious,
    output logic               err_overflow
);

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  in_twn_q, in_twn_d;
    logic [15:0]       issued_q, issued_d;
    logic [15:0]       results_q, results_d;
    logic [FID_W-1:0]  fid_q, fid_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              twn_vld_in_q, twn_vld_in_d;
    logic [63:0]       twn_data_in_q, twn_data_in_d;
    logic              err_spurious_q, err_spurious_d;
    logic              err_overflow_q, err_overflow_d;

    logic              beat_acc_s, frame_done_s, credit_ok_s, run_done_s;
    logic              spurious_s, overflow_s, push_s, pop_s, ret_s;
    pred_entry_t       push_entry_s, head_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_full_s, fifo_empty_s;

    pred_fifo #(.DEPTH(MAX_INFLIGHT)) u_pred_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Handshake decode, credit accounting and FSM next-state.
    always_comb begin
        beat_acc_s   = ready_q && i_in_TVALID && q_in_TVALID;
        frame_done_s = beat_acc_s && (beat_cnt_q == BEAT_W'(BEATS_PER_FRAME - 1));
        pop_s        = !fifo_empty_s && predictions_TREADY;
        spurious_s   = twn_vld_out && (in_twn_q == {CNT_W{1'b0}});
        ret_s        = twn_vld_out && !spurious_s;
        overflow_s   = ret_s && fifo_full_s && !pop_s;
        push_s       = ret_s && !overflow_s;
        // Admitted-but-unsent frames are those in the TWN plus those queued.
        credit_ok_s  = ({1'b0, in_twn_q} + {1'b0, fifo_count_s}) < (CNT_W + 1)'(MAX_INFLIGHT);
        run_done_s   = (cfg_num_frames != 16'd0) && (issued_q == cfg_num_frames);

        push_entry_s.fid    = fid_q;
        push_entry_s.last   = (cfg_num_frames != 16'd0) && ((results_q + 16'd1) == cfg_num_frames);
        push_entry_s.scores = twn_data_out;

        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        issued_d       = issued_q;
        results_d      = results_q + 16'(push_s);
        fid_d          = fid_q + FID_W'(push_s);
        in_twn_d       = in_twn_q + CNT_W'(frame_done_s) - CNT_W'(ret_s);
        err_spurious_d = err_spurious_q || spurious_s;
        err_overflow_d = err_overflow_q || overflow_s;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start && cfg_enable) begin
                    state_d   = ST_WAIT_CREDIT;
                    issued_d  = 16'd0;
                    results_d = 16'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_CREDIT: begin
                if (!cfg_enable || run_done_s) begin
                    state_d = ST_DRAIN;
                end else if (credit_ok_s) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_WAIT_CREDIT;
                end
            end
            ST_STREAM: begin
                if (frame_done_s) begin
                    beat_cnt_d = {BEAT_W{1'b0}};
                    issued_d   = issued_q + 16'd1;
                    state_d    = ST_WAIT_CREDIT;
                end else if (beat_acc_s) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            ST_DRAIN: begin
                if ((in_twn_q == {CNT_W{1'b0}}) && fifo_empty_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d       = (state_d == ST_STREAM);
        busy_d        = (state_d != ST_IDLE);
        twn_vld_in_d  = beat_acc_s;
        twn_data_in_d = beat_acc_s ? {i_in_TDATA[15:0], q_in_TDATA[15:0],
                                      i_in_TDATA[31:16], q_in_TDATA[31:16]} : 64'd0;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            beat_cnt_q     <= {BEAT_W{1'b0}};
            in_twn_q       <= {CNT_W{1'b0}};
            issued_q       <= 16'd0;
            results_q      <= 16'd0;
            fid_q          <= {FID_W{1'b0}};
            ready_q        <= 1'b0;
            busy_q         <= 1'b0;
            twn_vld_in_q   <= 1'b0;
            twn_data_in_q  <= 64'd0;
            err_spurious_q <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            in_twn_q       <= in_twn_d;
            issued_q       <= issued_d;
            results_q      <= results_d;
            fid_q          <= fid_d;
            ready_q        <= ready_d;
            busy_q         <= busy_d;
            twn_vld_in_q   <= twn_vld_in_d;
            twn_data_in_q  <= twn_data_in_d;
            err_spurious_q <= err_spurious_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign i_in_TREADY        = ready_q;
    assign q_in_TREADY        = ready_q;
    assign twn_vld_in         = twn_vld_in_q;
    assign twn_data_in        = twn_data_in_q;
    assign predictions_TVALID = !fifo_empty_s;
    assign predictions_TDATA  = fifo_empty_s ? {TDATA_W{1'b0}} : pack_tdata(head_s);
    assign predictions_TLAST  = !fifo_empty_s && head_s.last;
    assign busy               = busy_q;
    assign err_spurious       = err_spurious_q;
    assign err_overflow       = err_overflow_q;

endmodule

// File: tb/tb_twn_frame_sequencer.sv
// Scoreboard bench for twn_frame_sequencer with a delayed-return TWN model.
module tb_twn_frame_sequencer;

    localparam int BPF = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_enable = 1'b0;
    logic         cfg_start = 1'b0;
    logic [15:0]  cfg_num_frames = 16'd0;
    logic [31:0]  i_in_TDATA = 32'd0;
    logic         i_in_TVALID = 1'b0;
    logic         i_in_TREADY;
    logic [31:0]  q_in_TDATA = 32'd0;
    logic         q_in_TVALID = 1'b0;
    logic         q_in_TREADY;
    logic         twn_vld_in;
    logic [63:0]  twn_data_in;
    logic         twn_vld_out;
    logic [63:0]  twn_data_out;
    logic [511:0] predictions_TDATA;
    logic         predictions_TVALID;
    logic         predictions_TLAST;
    logic         predictions_TREADY = 1'b0;
    logic         busy;
    logic         err_spurious;
    logic         err_overflow;

    logic         model_vld = 1'b0;
    logic [63:0]  model_scores = 64'd0;
    logic         inj_vld = 1'b0;
    logic [63:0]  inj_scores = 64'd0;

    assign twn_vld_out  = model_vld | inj_vld;
    assign twn_data_out = inj_vld ? inj_scores : model_scores;

    twn_frame_sequencer #(.BEATS_PER_FRAME(BPF), .MAX_INFLIGHT(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_enable         (cfg_enable),
        .cfg_start          (cfg_start),
        .cfg_num_frames     (cfg_num_frames),
        .i_in_TDATA         (i_in_TDATA),
        .i_in_TVALID        (i_in_TVALID),
        .i_in_TREADY        (i_in_TREADY),
        .q_in_TDATA         (q_in_TDATA),
        .q_in_TVALID        (q_in_TVALID),
        .q_in_TREADY        (q_in_TREADY),
        .twn_vld_in         (twn_vld_in),
        .twn_data_in        (twn_data_in),
        .twn_vld_out        (twn_vld_out),
        .twn_data_out       (twn_data_out),
        .predictions_TDATA  (predictions_TDATA),
        .predictions_TVALID (predictions_TVALID),
        .predictions_TLAST  (predictions_TLAST),
        .predictions_TREADY (predictions_TREADY),
        .busy               (busy),
        .err_spurious       (err_spurious),
        .err_overflow       (err_overflow)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           vld_in_cnt = 0;
    int           model_beats = 0;
    int           model_n = 0;
    int           run_frames = 0;
    int           res_cnt = 0;
    int           base = 0;
    logic [15:0]  exp_fid = 16'd0;
    logic [15:0]  seq = 16'd0;
    logic [15:0]  off;
    bit           feed_en = 1'b0;
    bit           misalign = 1'b0;
    bit           acc_pending = 1'b0;
    bit           prev_hold = 1'b0;
    logic [511:0] prev_tdata;
    logic [511:0] etd;
    logic [512:0] se;
    logic [63:0]  eb;
    logic [63:0]  beat_q[$];
    logic [512:0] sb[$];
    int           due[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // I/Q source: a new sample pair after every accepted beat.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (acc_pending) seq = seq + 16'd1;
            i_in_TVALID = feed_en;
            q_in_TVALID = feed_en && !misalign;
            i_in_TDATA  = {seq + 16'h1000, seq};
            q_in_TDATA  = {seq + 16'h3000, seq + 16'h2000};
        end
    end

    // Monitor, TWN model and scoreboards, all sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                beat_q.delete(); sb.delete(); due.delete();
                model_beats = 0; model_n = 0; exp_fid = 16'd0;
                acc_pending = 1'b0; prev_hold = 1'b0; model_vld = 1'b0;
            end else begin
                if (twn_vld_in) begin
                    vld_in_cnt++;
                    chk("beat_expected", beat_q.size() > 0, 1'b1);
                    if (beat_q.size() > 0) chk("beat_data", twn_data_in, beat_q.pop_front());
                    model_beats++;
                    if (model_beats == BPF) begin
                        due.push_back(cyc + 20);
                        model_beats = 0;
                    end
                end else begin
                    chk("beat_idle_zero", twn_data_in, 64'd0);
                end
                chk("ready_pair", i_in_TREADY, q_in_TREADY);
                acc_pending = i_in_TVALID && q_in_TVALID && i_in_TREADY && q_in_TREADY;
                if (acc_pending) begin
                    eb = {i_in_TDATA[15:0], q_in_TDATA[15:0], i_in_TDATA[31:16], q_in_TDATA[31:16]};
                    beat_q.push_back(eb);
                end
                if (prev_hold) begin
                    chk("tvalid_held", predictions_TVALID, 1'b1);
                    chk("tdata_stable", predictions_TDATA, prev_tdata);
                end
                if (predictions_TVALID && predictions_TREADY) begin
                    chk("pred_expected", sb.size() > 0, 1'b1);
                    if (sb.size() > 0) begin
                        se = sb.pop_front();
                        chk("pred_tdata", predictions_TDATA, se[511:0]);
                        chk("pred_tlast", predictions_TLAST, se[512]);
                    end
                end
                prev_hold  = predictions_TVALID && !predictions_TREADY;
                prev_tdata = predictions_TDATA;
                model_vld = 1'b0;
                if (due.size() > 0 && due[0] == cyc) begin
                    void'(due.pop_front());
                    off = 16'(model_n) << 4;
                    model_scores = {16'd4 + off, 16'd3 + off, 16'd2 + off, 16'd1 + off};
                    model_vld = 1'b1;
                    etd = 512'd0;
                    etd[63:0] = model_scores;
                    etd[511:496] = exp_fid;
                    sb.push_back({(run_frames != 0) && (res_cnt + 1 == run_frames), etd});
                    exp_fid = exp_fid + 16'd1;
                    res_cnt++;
                    model_n++;
                end
            end
        end
    end

    task automatic do_reset();
        step();
        rst = 1'b1;
        feed_en = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_i_ready"}, i_in_TREADY, 1'b0);
        chk({tag, "_q_ready"}, q_in_TREADY, 1'b0);
        chk({tag, "_vld_in"}, twn_vld_in, 1'b0);
        chk({tag, "_data_in"}, twn_data_in, 64'd0);
        chk({tag, "_tvalid"}, predictions_TVALID, 1'b0);
        chk({tag, "_tdata"}, predictions_TDATA, 512'd0);
        chk({tag, "_tlast"}, predictions_TLAST, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err_spurious"}, err_spurious, 1'b0);
        chk({tag, "_err_overflow"}, err_overflow, 1'b0);
    endtask

    task automatic start_run(input int n);
        step();
        run_frames = n;
        res_cnt = 0;
        cfg_num_frames = 16'(n);
        cfg_enable = 1'b1;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 400; k++) begin
            if (!busy) break;
            step();
        end
        chk(tag, busy, 1'b0);
    endtask

    task automatic wait_cnt(input int target, input string tag);
        for (int k = 0; k < 400; k++) begin
            if (vld_in_cnt == target) break;
            step();
        end
        chk(tag, vld_in_cnt, target);
    endtask

    task automatic wait_tvalid(input string tag);
        for (int k = 0; k < 400; k++) begin
            if (predictions_TVALID) break;
            step();
        end
        chk(tag, predictions_TVALID, 1'b1);
    endtask

    task automatic pulse_tready();
        predictions_TREADY = 1'b1;
        step();
        predictions_TREADY = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check_outputs_zero("reset");

        // Single finite frame.
        base = vld_in_cnt;
        predictions_TREADY = 1'b1;
        feed_en = 1'b1;
        start_run(1);
        wait_idle("t1_idle");
        feed_en = 1'b0;
        chk("t1_vld_in_pulses", vld_in_cnt - base, 8);
        chk("t1_sb_empty", sb.size(), 0);

        // Credit stall in continuous mode with the host link blocked.
        base = vld_in_cnt;
        predictions_TREADY = 1'b0;
        feed_en = 1'b1;
        start_run(0);
        wait_cnt(base + 16, "t2_two_frames");
        wait_tvalid("t2_pred_queued");
        repeat (40) step();
        chk("t2_i_ready_stall", i_in_TREADY, 1'b0);
        chk("t2_q_ready_stall", q_in_TREADY, 1'b0);
        chk("t2_no_third_frame", vld_in_cnt - base, 16);
        pulse_tready();
        for (int k = 0; k < 3; k++) begin
            if (i_in_TREADY) break;
            step();
        end
        chk("t2_ready_resume", i_in_TREADY, 1'b1);
        cfg_enable = 1'b0;
        predictions_TREADY = 1'b1;
        wait_idle("t2_idle");
        feed_en = 1'b0;
        chk("t2_vld_in_pulses", vld_in_cnt - base, 24);
        chk("t2_sb_empty", sb.size(), 0);

        // Misaligned valids are neither accepted nor consumed.
        misalign = 1'b1;
        feed_en = 1'b1;
        start_run(1);
        for (int k = 0; k < 20; k++) begin
            if (i_in_TREADY) break;
            step();
        end
        chk("t3_stream", i_in_TREADY, 1'b1);
        base = vld_in_cnt;
        repeat (5) step();
        chk("t3_no_beat", vld_in_cnt - base, 0);
        misalign = 1'b0;
        wait_idle("t3_idle");
        feed_en = 1'b0;
        chk("t3_vld_in_pulses", vld_in_cnt - base, 8);
        chk("t3_sb_empty", sb.size(), 0);

        // Enable dropped mid-frame: frame completes, nothing more admitted.
        base = vld_in_cnt;
        feed_en = 1'b1;
        start_run(0);
        wait_cnt(base + 3, "t4_three_beats");
        cfg_enable = 1'b0;
        wait_idle("t4_idle");
        feed_en = 1'b0;
        chk("t4_vld_in_pulses", vld_in_cnt - base, 8);
        chk("t4_sb_empty", sb.size(), 0);
        chk("t4_no_spurious", err_spurious, 1'b0);
        chk("t4_no_overflow", err_overflow, 1'b0);

        // Spurious TWN result while idle.
        inj_scores = 64'h0BAD_0BAD_0BAD_0BAD;
        inj_vld = 1'b1;
        step();
        inj_vld = 1'b0;
        step();
        chk("t5_spurious_set", err_spurious, 1'b1);
        chk("t5_no_output", predictions_TVALID, 1'b0);
        repeat (10) step();
        chk("t5_spurious_sticky", err_spurious, 1'b1);
        chk("t5_still_no_output", predictions_TVALID, 1'b0);
        chk("t5_no_overflow", err_overflow, 1'b0);

        // Reset mid-frame with one prediction queued.
        base = vld_in_cnt;
        predictions_TREADY = 1'b0;
        feed_en = 1'b1;
        start_run(0);
        wait_cnt(base + 16, "t6_two_frames");
        wait_tvalid("t6_pred_queued");
        repeat (30) step();
        pulse_tready();
        wait_cnt(base + 21, "t6_mid_frame");
        chk("t6_spurious_before_rst", err_spurious, 1'b1);
        do_reset();
        check_outputs_zero("t6_after_rst");
        base = vld_in_cnt;
        predictions_TREADY = 1'b1;
        feed_en = 1'b1;
        start_run(1);
        wait_idle("t6_idle");
        feed_en = 1'b0;
        chk("t6_vld_in_pulses", vld_in_cnt - base, 8);
        chk("t6_sb_empty", sb.size(), 0);
        chk("t6_no_overflow", err_overflow, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/twn_frame_sequencer.md
Name: twn_frame_sequencer

Overview:
Sequences the ternary-weight network (TWN) classifier datapath on a frame basis. Accepts joint I/Q AXIS beats from the RF data converter and forwards whole frames of BEATS_PER_FRAME beats into the TWN. Admits a new frame only when a result slot is guaranteed, tags each returned prediction with a frame id, and buffers predictions for the host AXIS link. Sits between the RF data converter, the TWN core and the host DMA.

Parameters:
CLASSES, 4, number of 16-bit class scores per prediction
BEATS_PER_FRAME, 256, input beats (4 samples each) per classified frame
MAX_INFLIGHT, 4, prediction FIFO depth = max frames admitted but not yet sent to the host
FID_W, 16, frame id width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_enable  in  1  level; run permitted
cfg_start  in  1  single-cycle pulse; begin a run (ignored unless IDLE and cfg_enable)
cfg_num_frames  in  16  frames per run; 0 = continuous until cfg_enable drops
i_in_TDATA  in  32  I samples
i_in_TVALID  in  1
i_in_TREADY  out  1
q_in_TDATA  in  32  Q samples
q_in_TVALID  in  1
q_in_TREADY  out  1
twn_vld_in  out  1  beat valid into TWN
twn_data_in  out  4x16  {i[15:0], q[15:0], i[31:16], q[31:16]}, index 3..0
twn_vld_out  in  1  prediction valid from TWN
twn_data_out  in  CLASSESx16  class scores
predictions_TDATA  out  512  [16*CLASSES-1:0] scores; [511:512-FID_W] frame id; other bits 0
predictions_TVALID  out  1
predictions_TLAST  out  1  1 on the last frame of a finite run, else 0
predictions_TREADY  in  1
busy  out  1  state != IDLE
err_spurious  out  1  sticky; twn_vld_out with zero frames outstanding in TWN
err_overflow  out  1  sticky; twn_vld_out with prediction FIFO full

Behaviour:
- Reset: state IDLE. All outputs 0, counters 0, FIFO empty, sticky errors cleared. Reset mid-frame discards the partial frame and all queued predictions.
- States: IDLE, WAIT_CREDIT, STREAM, DRAIN.
- IDLE -> WAIT_CREDIT on cfg_start & cfg_enable. Clears issued-frame count. The frame id continues from its last value; it resets only on rst.
- WAIT_CREDIT -> STREAM when credits = MAX_INFLIGHT - (in_twn + fifo_count) > 0. Goes to DRAIN instead when cfg_enable=0 or the issued count equals a nonzero cfg_num_frames.
- STREAM: i_in_TREADY = q_in_TREADY = 1. A beat is accepted when both TVALIDs are high. A single valid is not accepted and not consumed.
- After the BEATS_PER_FRAME-th beat: in_twn++ and issued++, then STREAM -> WAIT_CREDIT.
- cfg_enable falling mid-frame does not truncate; the current frame completes.
- READYs are 0 in all states except STREAM.
- Accepted beat at cycle t -> twn_vld_in=1 with registered data at t+1. twn_vld_in=0 otherwise; data zeroed when not valid.
- twn_vld_out at t: write {frame_id_out, last_flag, scores} into the FIFO and decrement in_twn. frame_id_out increments modulo 2^FID_W. predictions_TVALID rises at t+1 if the FIFO was empty.
- last_flag = 1 when cfg_num_frames != 0 and this is the cfg_num_frames-th result of the run.
- Output handshake: pop on TVALID & TREADY. TDATA and TLAST are stable while TVALID=1 and TREADY=0. A simultaneous push and pop is legal at any occupancy, including full.
- twn_vld_out with in_twn=0: set err_spurious, drop, no state change.
- twn_vld_out with FIFO full and no simultaneous pop: set err_overflow, drop. This is unreachable under correct credit accounting; the bench checks it never fires.
- DRAIN -> IDLE when in_twn=0, FIFO empty and no TVALID pending.
- Counter widths: in_twn and fifo_count are clog2(MAX_INFLIGHT+1). The beat counter is clog2(BEATS_PER_FRAME).

Decomposition:
- Package twn_sched_pkg: state enum, pred_entry_t struct {fid, last, scores}, FID_W and TDATA_W=512 constants.
- One sub-module: pred_fifo, a synchronous FIFO with registered output. Parameters: depth MAX_INFLIGHT, width = pred_entry_t. Provides count, full and empty, and supports simultaneous push/pop when full.

Test Plan:
(Bench uses BEATS_PER_FRAME=8, MAX_INFLIGHT=2, CLASSES=4.)
1. Single frame: cfg_num_frames=1, start, 8 continuous I/Q beats; TWN model returns scores {1,2,3,4} 20 cycles later -> exactly 8 twn_vld_in pulses. TDATA[63:0]=0x0004_0003_0002_0001, fid 0, TLAST=1, busy drops after the pop.
2. Credit stall: cfg_num_frames=0, TREADY held 0, predictions returned -> after 2 frames issued, i/q_in_TREADY stay 0. Raising TREADY for one pop re-enables input within 2 cycles.
3. Misaligned valids: i_in_TVALID high, q_in_TVALID low for 5 cycles -> no twn_vld_in and the beat count is unchanged. The beat counts once both are high.
4. Disable mid-frame: cfg_enable dropped after beat 3 -> beats 4-8 still accepted. No further frame admitted, state reaches DRAIN then IDLE, TLAST=0 throughout (continuous mode).
5. Error flags: twn_vld_out injected while idle -> err_spurious=1 and no output beat. The flag stays set until rst.
6. Reset mid-frame: rst asserted after beat 5 with one prediction queued -> next cycle all outputs 0 and FIFO empty. A new run starts at beat 0 with fid 0.
